// File: rtl/agc_monitor_ctrl.sv
// agc_monitor_ctrl: sequences host run/halt/step/load commands
// against AGC timepulses MT01..MT12 and drives the monitor inputs.
module agc_monitor_ctrl #(
  parameter int SYNC_STAGES   = 2,
  parameter int STRT_CYCLES   = 8,
  parameter int TIMEOUT_CYC   = 4095,
  parameter int LOAD_TP_START = 7,
  parameter int LOAD_TP_END   = 10
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_data,
  input  logic [11:0] mt,
  input  logic        MGOJAM,
  output logic        MSTP,
  output logic        MSTRTP,
  output logic        MONWBK,
  output logic [15:0] mdt,
  output logic        halted,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_STEP_PULSE,
    S_STEP_WAIT,
    S_LOAD_ARM,
    S_LOAD_DRIVE
  } state_t;

  localparam logic [1:0]  OP_RUN  = 2'd0;
  localparam logic [1:0]  OP_HALT = 2'd1;
  localparam logic [1:0]  OP_STEP = 2'd2;
  localparam logic [1:0]  OP_LOAD = 2'd3;
  localparam logic [11:0] L_TO    = 12'(TIMEOUT_CYC - 1);
  localparam logic [11:0] L_STRT  = 12'(STRT_CYCLES - 1);

  state_t                       r_state;
  logic [SYNC_STAGES-1:0][12:0] r_sync;
  logic [12:0]                  r_prev;
  logic [11:0]                  r_cnt;
  logic [15:0]                  r_data;
  logic                         r_mstp;
  logic                         r_mstrtp;
  logic                         r_monwbk;
  logic [15:0]                  r_mdt;
  logic                         r_done;
  logic                         r_err;

  logic [12:0] w_edge;
  logic        w_gj;
  logic        w_wait;
  logic        w_hit;
  logic        w_abort;
  logic        w_unused;

  // bit 12 carries MGOJAM; bits 11..0 carry MT12..MT01
  assign w_edge   = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_gj     = w_edge[12];
  assign w_unused = ^w_edge;

  assign w_wait = (r_state == S_HALT_WAIT)
               || (r_state == S_STEP_WAIT)
               || (r_state == S_LOAD_ARM)
               || (r_state == S_LOAD_DRIVE);

  // the MT edge each wait state is looking for
  always_comb begin
    w_hit = 1'b0;
    unique case (r_state)
      S_HALT_WAIT,
      S_STEP_WAIT:  w_hit = w_edge[11];
      S_LOAD_ARM:   w_hit = w_edge[LOAD_TP_START-1];
      S_LOAD_DRIVE: w_hit = w_edge[LOAD_TP_END-1];
      default:      w_hit = 1'b0;
    endcase
  end

  // GOJAM beats MT edges; an MT edge beats the timeout
  assign w_abort = (r_state != S_IDLE)
                && (w_gj || (w_wait && !w_hit
                             && r_cnt == L_TO));

  // synchronize MT and MGOJAM, keep previous for edge detect
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= {MGOJAM, mt};
      for (int i = 1; i < SYNC_STAGES; i++)
        r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // command sequencer with registered monitor outputs
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_data   <= '0;
      r_mstp   <= 1'b0;
      r_mstrtp <= 1'b0;
      r_monwbk <= 1'b0;
      r_mdt    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == S_IDLE) begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_RUN: begin
              r_mstp <= 1'b0;
              r_done <= 1'b1;
            end
            OP_HALT: begin
              r_mstp <= 1'b1;
              if (r_mstp) begin
                r_done <= 1'b1;
              end else begin
                r_state <= S_HALT_WAIT;
                r_cnt   <= '0;
              end
            end
            OP_STEP: begin
              if (!r_mstp) begin
                r_done <= 1'b1;
                r_err  <= 1'b1;
              end else begin
                r_state  <= S_STEP_PULSE;
                r_mstrtp <= 1'b1;
                r_cnt    <= '0;
              end
            end
            OP_LOAD: begin
              r_data  <= cmd_data;
              r_state <= S_LOAD_ARM;
              r_cnt   <= '0;
            end
          endcase
        end
      end else if (w_abort) begin
        r_mstrtp <= 1'b0;
        r_monwbk <= 1'b0;
        r_mdt    <= '0;
        r_done   <= 1'b1;
        r_err    <= 1'b1;
        r_state  <= S_IDLE;
      end else begin
        unique case (r_state)
          S_STEP_PULSE: begin
            if (r_cnt == L_STRT) begin
              r_mstrtp <= 1'b0;
              r_state  <= S_STEP_WAIT;
              r_cnt    <= '0;
            end else begin
              r_cnt <= r_cnt + 12'd1;
            end
          end
          S_HALT_WAIT,
          S_STEP_WAIT: begin
            if (w_hit) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 12'd1;
            end
          end
          S_LOAD_ARM: begin
            if (w_hit) begin
              r_mdt    <= r_data;
              r_monwbk <= 1'b1;
              r_state  <= S_LOAD_DRIVE;
              r_cnt    <= '0;
            end else begin
              r_cnt <= r_cnt + 12'd1;
            end
          end
          S_LOAD_DRIVE: begin
            if (w_hit) begin
              r_mdt    <= '0;
              r_monwbk <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 12'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign MSTP      = r_mstp;
  assign halted    = r_mstp;
  assign MSTRTP    = r_mstrtp;
  assign MONWBK    = r_monwbk;
  assign mdt       = r_mdt;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_agc_monitor_ctrl.sv
// tb_agc_monitor_ctrl: directed checks of the AGC monitor
// sequencer with hand-derived expected values.
module tb_agc_monitor_ctrl;

  logic        SIM_CLK = 1'b0;
  logic        SIM_RST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [11:0] mt;
  logic        MGOJAM;
  logic        MSTP;
  logic        MSTRTP;
  logic        MONWBK;
  logic [15:0] mdt;
  logic        halted;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  agc_monitor_ctrl dut (
    .SIM_CLK   (SIM_CLK),
    .SIM_RST   (SIM_RST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .mt        (mt),
    .MGOJAM    (MGOJAM),
    .MSTP      (MSTP),
    .MSTRTP    (MSTRTP),
    .MONWBK    (MONWBK),
    .mdt       (mdt),
    .halted    (halted),
    .done      (done),
    .err       (err)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  task automatic tick();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op,
                      input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mstp"},   MSTP,      1'b0);
    chk({tag, "_strt"},   MSTRTP,    1'b0);
    chk({tag, "_wbk"},    MONWBK,    1'b0);
    chk({tag, "_mdt"},    mdt,       16'h0);
    chk({tag, "_halted"}, halted,    1'b0);
    chk({tag, "_done"},   done,      1'b0);
    chk({tag, "_err"},    err,       1'b0);
    chk({tag, "_ready"},  cmd_ready, 1'b1);
  endtask

  initial begin
    int n_hi;
    int k;
    logic drop;
    logic leak;

    SIM_RST   = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = 16'h0;
    mt        = 12'h0;
    MGOJAM    = 1'b0;
    ticks(3);
    chk_reset("rst");
    SIM_RST = 1'b0;
    tick();

    // 1: HALT, done three cycles after MT12 rises
    send(2'd1, 16'h0);
    chk("halt_mstp",  MSTP,      1'b1);
    chk("halt_hltd",  halted,    1'b1);
    chk("halt_ready", cmd_ready, 1'b0);
    mt[0] = 1'b1;
    ticks(5);
    mt[0] = 1'b0;
    ticks(10);
    chk("halt_nodone", done, 1'b0);
    mt[11] = 1'b1;
    ticks(2);
    chk("halt_early", done, 1'b0);
    tick();
    chk("halt_done",  done,      1'b1);
    chk("halt_err",   err,       1'b0);
    chk("halt_rdy2",  cmd_ready, 1'b1);
    tick();
    chk("halt_pulse", done, 1'b0);
    mt[11] = 1'b0;
    ticks(5);

    // 2: STEP while halted, MSTRTP exactly 8 cycles
    send(2'd2, 16'h0);
    n_hi = 0;
    drop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (MSTRTP) n_hi++;
      if (!MSTP) drop = 1'b1;
      if (i != 19) tick();
    end
    chk("step_len",   n_hi, 8);
    chk("step_wait",  done, 1'b0);
    mt[11] = 1'b1;
    ticks(2);
    if (!MSTP) drop = 1'b1;
    chk("step_early", done, 1'b0);
    tick();
    chk("step_done",  done, 1'b1);
    chk("step_err",   err,  1'b0);
    chk("step_drop",  drop, 1'b0);
    mt[11] = 1'b0;
    ticks(5);

    // 3: LOAD A5C3 between MT07 and MT10 edges
    send(2'd3, 16'hA5C3);
    chk("ld_arm_mdt", mdt, 16'h0);
    mt[9] = 1'b1;
    ticks(4);
    chk("ld_arm_mt10", mdt,    16'h0);
    chk("ld_arm_wbk",  MONWBK, 1'b0);
    mt[9] = 1'b0;
    ticks(4);
    mt[6] = 1'b1;
    ticks(2);
    chk("ld_pre_mdt", mdt, 16'h0);
    tick();
    chk("ld_mdt",     mdt,    16'hA5C3);
    chk("ld_wbk",     MONWBK, 1'b1);
    ticks(5);
    mt[9] = 1'b1;
    ticks(2);
    chk("ld_hold",    mdt,    16'hA5C3);
    tick();
    chk("ld_end_mdt", mdt,    16'h0);
    chk("ld_end_wbk", MONWBK, 1'b0);
    chk("ld_done",    done,   1'b1);
    chk("ld_err",     err,    1'b0);
    mt = 12'h0;
    ticks(5);

    // 4: RUN, then STEP while running is illegal
    send(2'd0, 16'h0);
    chk("run_mstp", MSTP, 1'b0);
    chk("run_done", done, 1'b1);
    chk("run_err",  err,  1'b0);
    tick();
    send(2'd2, 16'h0);
    chk("ill_done",  done,      1'b1);
    chk("ill_err",   err,       1'b1);
    chk("ill_strt",  MSTRTP,    1'b0);
    chk("ill_ready", cmd_ready, 1'b1);
    tick();
    chk("ill_strt2", MSTRTP, 1'b0);
    chk("ill_pulse", done,   1'b0);

    // 5: HALT with MT frozen times out after 4095 cycles
    send(2'd1, 16'h0);
    k = 0;
    while (done !== 1'b1 && k < 5000) begin
      tick();
      k++;
    end
    chk("to_cycles", k,         4095);
    chk("to_err",    err,       1'b1);
    chk("to_mstp",   MSTP,      1'b1);
    chk("to_ready",  cmd_ready, 1'b1);
    tick();
    send(2'd1, 16'h0);
    chk("rehalt_done", done, 1'b1);
    chk("rehalt_err",  err,  1'b0);

    // 6a: GOJAM during LOAD_DRIVE beats a same-cycle MT10 edge
    tick();
    send(2'd3, 16'h1234);
    mt[6] = 1'b1;
    ticks(3);
    chk("gj_wbk_on", MONWBK, 1'b1);
    chk("gj_mdt_on", mdt,    16'h1234);
    MGOJAM = 1'b1;
    mt[9]  = 1'b1;
    ticks(3);
    chk("gj_mdt",  mdt,    16'h0);
    chk("gj_wbk",  MONWBK, 1'b0);
    chk("gj_done", done,   1'b1);
    chk("gj_err",  err,    1'b1);
    chk("gj_mstp", MSTP,   1'b1);
    MGOJAM = 1'b0;
    mt     = 12'h0;
    ticks(5);
    MGOJAM = 1'b1;
    leak = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) leak = 1'b1;
    end
    chk("gj_idle", leak, 1'b0);
    MGOJAM = 1'b0;
    ticks(4);

    // 6b: reset in the middle of STEP_PULSE
    send(2'd2, 16'h0);
    ticks(2);
    chk("rs_strt", MSTRTP, 1'b1);
    SIM_RST = 1'b1;
    tick();
    chk_reset("rs");
    SIM_RST = 1'b0;
    tick();
    chk("rs_nodone", done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
